// File: rtl/herald_cmd_bridge.sv
// herald_cmd_bridge: byte-serial host bridge between the 8-bit pin bus and
// one execution engine. It latches a command and its operands, launches the
// engine, and returns the result bytes or a status byte. An engine timeout
// and a host abort both return the bridge to a known state.
module herald_cmd_bridge #(
  parameter int unsigned OPW     = 24,
  parameter int unsigned RESW    = 72,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      bus_din,
  input  logic            wr_strobe,
  input  logic            rd_strobe,
  input  logic            abort_strobe,
  output logic [7:0]      bus_dout,
  output logic [7:0]      eng_cmd,
  output logic [OPW-1:0]  eng_op_a,
  output logic [OPW-1:0]  eng_op_b,
  output logic            eng_start,
  output logic            eng_abort,
  input  logic            dec_legal,
  input  logic [1:0]      dec_nops,
  input  logic [3:0]      dec_nres,
  input  logic            eng_done,
  input  logic [RESW-1:0] eng_res
);

  localparam int unsigned OPB = OPW / 8;
  localparam int unsigned RB  = RESW / 8;
  localparam int unsigned IW  = $clog2(2 * OPB) + 1;
  localparam int unsigned CW  = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]    RB4      = 4'(RB);
  // The abort pulse is registered, so the decision is taken one count early.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_OPERAND, S_WAIT, S_RESULT, S_ERROR
  } state_t;

  state_t          state, state_n;
  logic            wr_prev, rd_prev, ab_prev;
  logic            wr_e, rd_e, ab_e;
  logic [IW-1:0]   bidx, op_last;
  logic [1:0]      nops_r;
  logic [RESW-1:0] res_r;
  logic [3:0]      nbytes, ridx, n_eff;
  logic [CW-1:0]   cnt;
  logic            err, cause, hold;
  logic [7:0]      res_byte, status;

  logic latch_cmd, op_we, start_p, abort_p, capture, set_err, set_cause;
  logic clr_err, rd_load, clr_cnt, clr_bidx;

  assign wr_e    = wr_strobe & ~wr_prev;
  assign rd_e    = rd_strobe & ~rd_prev;
  assign ab_e    = abort_strobe & ~ab_prev;
  assign n_eff   = (dec_nres > RB4) ? RB4 : dec_nres;
  assign op_last = (nops_r == 2'd2) ? IW'(2 * OPB - 1) : IW'(OPB - 1);

  // Select the result byte addressed by the read index.
  always_comb begin
    res_byte = '0;
    for (int unsigned i = 0; i < RB; i++)
      if (ridx == 4'(i)) res_byte = res_r[i*8 +: 8];
  end

  // Status byte: BUSY, RDY, ERR, cause, bytes remaining.
  always_comb begin
    status = {(state == S_DECODE) || (state == S_OPERAND) || (state == S_WAIT),
              (state == S_RESULT), err, err & cause,
              (state == S_RESULT) ? (nbytes - ridx) : 4'd0};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and control decode; abort overrides every other event.
  always_comb begin
    state_n   = state;
    latch_cmd = 1'b0;
    op_we     = 1'b0;
    start_p   = 1'b0;
    abort_p   = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    set_cause = 1'b0;
    clr_err   = 1'b0;
    rd_load   = 1'b0;
    clr_cnt   = 1'b0;
    clr_bidx  = 1'b0;
    if (ab_e) begin
      state_n = S_IDLE;
      clr_err = 1'b1;
      abort_p = (state == S_WAIT);
    end else begin
      case (state)
        S_IDLE:
          if (wr_e) begin
            latch_cmd = 1'b1;
            state_n   = S_DECODE;
          end
        S_DECODE:
          if (!dec_legal || dec_nops == 2'd3) begin
            state_n = S_ERROR;
            set_err = 1'b1;
          end else if (dec_nops == 2'd0) begin
            state_n = S_WAIT;
            start_p = 1'b1;
            clr_cnt = 1'b1;
          end else begin
            state_n  = S_OPERAND;
            clr_bidx = 1'b1;
          end
        S_OPERAND:
          if (wr_e) begin
            op_we = 1'b1;
            if (bidx == op_last) begin
              state_n = S_WAIT;
              start_p = 1'b1;
              clr_cnt = 1'b1;
            end
          end
        S_WAIT:
          // eng_done in the launch cycle belongs to no command of ours.
          if (eng_done && !eng_start) begin
            capture = 1'b1;
            state_n = (n_eff == 4'd0) ? S_IDLE : S_RESULT;
          end else if (cnt == CNT_LAST) begin
            state_n   = S_ERROR;
            set_err   = 1'b1;
            set_cause = 1'b1;
            abort_p   = 1'b1;
          end
        S_RESULT:
          if (wr_e) begin
            latch_cmd = 1'b1;
            state_n   = S_DECODE;
          end else if (rd_e) begin
            rd_load = 1'b1;
            if (ridx == nbytes - 4'd1) state_n = S_IDLE;
          end
        S_ERROR: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath: strobe history, command/operand/result latches, counters, bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev   <= 1'b0;
      rd_prev   <= 1'b0;
      ab_prev   <= 1'b0;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      eng_cmd   <= '0;
      eng_op_a  <= '0;
      eng_op_b  <= '0;
      nops_r    <= '0;
      bidx      <= '0;
      cnt       <= '0;
      res_r     <= '0;
      nbytes    <= '0;
      ridx      <= '0;
      err       <= 1'b0;
      cause     <= 1'b0;
      hold      <= 1'b0;
      bus_dout  <= '0;
    end else begin
      wr_prev   <= wr_strobe;
      rd_prev   <= rd_strobe;
      ab_prev   <= abort_strobe;
      eng_start <= start_p;
      eng_abort <= abort_p;
      if (latch_cmd) eng_cmd <= bus_din;
      if (state == S_DECODE) nops_r <= dec_nops;
      if (clr_bidx)   bidx <= '0;
      else if (op_we) bidx <= bidx + IW'(1);
      if (op_we) begin
        for (int unsigned i = 0; i < OPB; i++) begin
          if (bidx == IW'(i))       eng_op_a[i*8 +: 8] <= bus_din;
          if (bidx == IW'(OPB + i)) eng_op_b[i*8 +: 8] <= bus_din;
        end
      end
      if (clr_cnt)              cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + CW'(1);
      if (capture) begin
        res_r  <= eng_res;
        nbytes <= n_eff;
        ridx   <= '0;
      end else if (rd_load) begin
        ridx <= ridx + 4'd1;
      end
      if (clr_err) begin
        err <= 1'b0;
      end else if (set_err) begin
        err   <= 1'b1;
        cause <= set_cause;
      end
      // A read byte stays on the bus while the host keeps rd_strobe high.
      if (rd_load) begin
        bus_dout <= res_byte;
        hold     <= 1'b1;
      end else if (!(hold && rd_strobe)) begin
        bus_dout <= status;
        hold     <= 1'b0;
      end
    end
  end

endmodule
